// File: rtl/ts_sched.sv
// Transmission scheduler: picks one queue from a gate-control bitmap by strict
// priority, fetches its metadata from MB, hands it to EBM and waits for completion.
module ts_sched #(
  parameter int MD_WIDTH   = 32,
  parameter int MD_TIMEOUT = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [3:0]             in_ts_schedule_valid,
  output logic [3:0]             out_ts_q_rden,
  output logic                   out_ts_q2_rden,
  input  logic                   in_ts_md_valid,
  input  logic [MD_WIDTH-1:0]    in_ts_md,
  output logic                   out_ts_md_valid,
  output logic [MD_WIDTH-1:0]    out_ts_md,
  output logic [1:0]             out_ts_qid,
  input  logic                   in_ts_md_ready,
  input  logic                   in_ts_pkt_done,
  output logic                   out_ts_busy,
  output logic [1:0]             out_ts_err,
  output logic [4*CNT_WIDTH-1:0] out_ts_q_cnt
);

  localparam int TW = $clog2(MD_TIMEOUT + 1);

  localparam logic [2:0] IDLE_S      = 3'd0;
  localparam logic [2:0] READ_S      = 3'd1;
  localparam logic [2:0] WAIT_MD_S   = 3'd2;
  localparam logic [2:0] SEND_S      = 3'd3;
  localparam logic [2:0] WAIT_DONE_S = 3'd4;

  logic [2:0]           r_state;
  logic [3:0]           r_q_rden;
  logic                 r_q2_rden;
  logic                 r_md_valid;
  logic [MD_WIDTH-1:0]  r_md;
  logic [1:0]           r_qid;
  logic                 r_busy;
  logic [1:0]           r_err;
  logic [TW-1:0]        r_tmo;
  logic [CNT_WIDTH-1:0] r_cnt [4];

  logic [1:0]           w_sel_qid;
  logic [3:0]           w_sel_oh;
  logic                 w_tmo_last;

  // Strict priority: lowest set bit wins, the rest of the bitmap is discarded.
  always_comb begin
    w_sel_qid = 2'd0;
    w_sel_oh  = 4'b0000;
    if (in_ts_schedule_valid[0]) begin
      w_sel_qid = 2'd0;
      w_sel_oh  = 4'b0001;
    end else if (in_ts_schedule_valid[1]) begin
      w_sel_qid = 2'd1;
      w_sel_oh  = 4'b0010;
    end else if (in_ts_schedule_valid[2]) begin
      w_sel_qid = 2'd2;
      w_sel_oh  = 4'b0100;
    end else if (in_ts_schedule_valid[3]) begin
      w_sel_qid = 2'd3;
      w_sel_oh  = 4'b1000;
    end
  end

  assign w_tmo_last = (r_tmo == TW'(MD_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE_S;
      r_q_rden   <= 4'b0000;
      r_q2_rden  <= 1'b0;
      r_md_valid <= 1'b0;
      r_md       <= '0;
      r_qid      <= 2'd0;
      r_busy     <= 1'b0;
      r_err      <= 2'b00;
      r_tmo      <= '0;
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      r_q_rden  <= 4'b0000;
      r_q2_rden <= 1'b0;
      if ((in_ts_schedule_valid != 4'b0000) && (r_state != IDLE_S))
        r_err[0] <= 1'b1;
      case (r_state)
        IDLE_S: begin
          if (in_ts_schedule_valid != 4'b0000) begin
            r_qid     <= w_sel_qid;
            r_q_rden  <= w_sel_oh;
            r_q2_rden <= w_sel_oh[2];
            r_busy    <= 1'b1;
            r_state   <= READ_S;
          end
        end
        READ_S: begin
          r_tmo   <= '0;
          r_state <= WAIT_MD_S;
        end
        // Metadata arriving on the expiry cycle still wins over the timeout.
        WAIT_MD_S: begin
          if (in_ts_md_valid) begin
            r_md       <= in_ts_md;
            r_md_valid <= 1'b1;
            r_state    <= SEND_S;
          end else if (w_tmo_last) begin
            r_err[1] <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= IDLE_S;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        SEND_S: begin
          if (in_ts_md_ready && r_md_valid) begin
            r_md_valid   <= 1'b0;
            r_cnt[r_qid] <= r_cnt[r_qid] + CNT_WIDTH'(1);
            r_state      <= WAIT_DONE_S;
          end
        end
        WAIT_DONE_S: begin
          if (in_ts_pkt_done) begin
            r_busy  <= 1'b0;
            r_state <= IDLE_S;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE_S;
        end
      endcase
    end
  end

  assign out_ts_q_rden   = r_q_rden;
  assign out_ts_q2_rden  = r_q2_rden;
  assign out_ts_md_valid = r_md_valid;
  assign out_ts_md       = r_md;
  assign out_ts_qid      = r_qid;
  assign out_ts_busy     = r_busy;
  assign out_ts_err      = r_err;

  for (genvar g = 0; g < 4; g++) begin : g_cnt
    assign out_ts_q_cnt[g*CNT_WIDTH +: CNT_WIDTH] = r_cnt[g];
  end

endmodule

// File: tb/tb_ts_sched.sv
// Bench for ts_sched: directed vector table, hand sequences for wrap/reset,
// and randomized packets scored against a transaction-level model.
module tb_ts_sched;

  localparam int MDW = 32;
  localparam int TMO = 16;
  localparam int CW  = 4;   // narrow counters so wraparound is reachable quickly

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [3:0]      sched = 4'b0000;
  logic [3:0]      q_rden;
  logic            q2_rden;
  logic            md_in_vld = 1'b0;
  logic [MDW-1:0]  md_in = '0;
  logic            md_vld;
  logic [MDW-1:0]  md_out;
  logic [1:0]      qid;
  logic            md_rdy = 1'b0;
  logic            pkt_done = 1'b0;
  logic            busy;
  logic [1:0]      err;
  logic [4*CW-1:0] q_cnt;

  int n_chk = 0;
  int n_pass = 0;
  int cnt_m [4];
  logic [1:0] err_m;

  ts_sched #(.MD_WIDTH(MDW), .MD_TIMEOUT(TMO), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_ts_schedule_valid(sched),
    .out_ts_q_rden(q_rden), .out_ts_q2_rden(q2_rden),
    .in_ts_md_valid(md_in_vld), .in_ts_md(md_in),
    .out_ts_md_valid(md_vld), .out_ts_md(md_out), .out_ts_qid(qid),
    .in_ts_md_ready(md_rdy), .in_ts_pkt_done(pkt_done),
    .out_ts_busy(busy), .out_ts_err(err), .out_ts_q_cnt(q_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]     bm;
    logic [MDW-1:0] md;
    int             dly;
    int             rdy;
    bit             spur_pulse;
    bit             spur_done;
    int             exp_q;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic int model_pick(input logic [3:0] bm);
    for (int i = 0; i < 4; i++) if (bm[i]) return i;
    return -1;
  endfunction

  function automatic logic [4*CW-1:0] model_cnt();
    logic [4*CW-1:0] v;
    for (int i = 0; i < 4; i++) v[i*CW +: CW] = cnt_m[i][CW-1:0];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) cnt_m[i] = 0;
    err_m = 2'b00;
  endtask

  // One full transaction: pulse, strobe, metadata (or timeout), handoff, completion.
  task automatic run_pkt(input vec_t v);
    logic [3:0] oh;
    oh = 4'b0001 << v.exp_q;
    sched = v.bm;
    tick();
    sched = 4'b0000;
    chk("strobe", q_rden, oh);
    chk("q2_strobe", q2_rden, (v.exp_q == 2));
    chk("busy_on", busy, 1'b1);
    tick();
    chk("strobe_1cyc", {q2_rden, q_rden}, 5'b0);
    if (v.dly >= TMO) begin
      repeat (TMO) tick();
      err_m[1] = 1'b1;
      chk("tmo_busy", busy, 1'b0);
      chk("tmo_err", err, err_m);
      md_in_vld = 1'b1;
      md_in = $urandom;
      tick();
      md_in_vld = 1'b0;
      chk("late_md_ignored", md_vld, 1'b0);
      chk("tmo_cnt", q_cnt, model_cnt());
      return;
    end
    repeat (v.dly) tick();
    md_in_vld = 1'b1;
    md_in = v.md;
    tick();
    md_in_vld = 1'b0;
    md_in = $urandom;
    chk("desc_vld", md_vld, 1'b1);
    chk("desc_md", md_out, v.md);
    chk("desc_qid", qid, v.exp_q);
    for (int r = 0; r < v.rdy; r++) begin
      pkt_done = v.spur_done && (r == 0);
      tick();
      pkt_done = 1'b0;
      chk("hold_vld", md_vld, 1'b1);
      chk("hold_md", md_out, v.md);
    end
    md_rdy = 1'b1;
    tick();
    md_rdy = 1'b0;
    cnt_m[v.exp_q] = (cnt_m[v.exp_q] + 1) % (1 << CW);
    chk("accept_vld_drop", md_vld, 1'b0);
    chk("accept_cnt", q_cnt, model_cnt());
    if (v.spur_pulse) begin
      sched = 4'b0001;
      tick();
      sched = 4'b0000;
      err_m[0] = 1'b1;
      chk("busy_pulse_no_strobe", q_rden, 4'b0000);
      chk("busy_pulse_err", err, err_m);
    end
    chk("wait_done_busy", busy, 1'b1);
    pkt_done = 1'b1;
    tick();
    pkt_done = 1'b0;
    chk("done_busy_off", busy, 1'b0);
  endtask

  vec_t tbl [7];
  vec_t rv;

  initial begin
    tbl[0] = '{4'b0100, 32'h0000_05DC, 0,  0, 1'b0, 1'b0, 2};
    tbl[1] = '{4'b1110, 32'hA5A5_0001, 1,  0, 1'b0, 1'b0, 1};
    tbl[2] = '{4'b0001, 32'h1234_5678, 0, 10, 1'b0, 1'b1, 0};
    tbl[3] = '{4'b0100, 32'h0BAD_0BAD, TMO, 0, 1'b0, 1'b0, 2};
    tbl[4] = '{4'b0001, 32'hCAFE_F00D, 2,  1, 1'b1, 1'b0, 0};
    tbl[5] = '{4'b0001, 32'h0000_0042, 0,  0, 1'b0, 1'b0, 0};
    tbl[6] = '{4'b1010, 32'hDEAD_BEEF, TMO-1, 2, 1'b0, 1'b0, 1};

    model_reset();
    #12;
    chk("rst_rden", {q2_rden, q_rden}, 5'b0);
    chk("rst_md", {md_vld, md_out}, 33'b0);
    chk("rst_busy_err_qid", {busy, err, qid}, 5'b0);
    chk("rst_cnt", q_cnt, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) run_pkt(tbl[i]);

    // Counter wraparound on Q3
    while (cnt_m[3] != (1 << CW) - 1) begin
      rv = '{4'b1000, $urandom, 0, 0, 1'b0, 1'b0, 3};
      run_pkt(rv);
    end
    chk("q3_at_max", q_cnt[3*CW +: CW], {CW{1'b1}});
    rv = '{4'b1000, 32'h0000_FFFF, 0, 0, 1'b0, 1'b0, 3};
    run_pkt(rv);
    chk("q3_wrap", q_cnt[3*CW +: CW], '0);

    // Randomized packets against the model
    for (int n = 0; n < 150; n++) begin
      rv.bm = 4'($urandom_range(1, 15));
      rv.md = $urandom;
      rv.dly = $urandom_range(0, TMO + 2);
      rv.rdy = $urandom_range(0, 4);
      rv.spur_pulse = ($urandom_range(0, 7) == 0);
      rv.spur_done = ($urandom_range(0, 3) == 0);
      rv.exp_q = model_pick(rv.bm);
      run_pkt(rv);
    end

    // Asynchronous reset while a descriptor is being offered
    sched = 4'b1000;
    tick();
    sched = 4'b0000;
    tick();
    md_in_vld = 1'b1;
    md_in = 32'h5555_AAAA;
    tick();
    md_in_vld = 1'b0;
    chk("pre_rst_desc", md_vld, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_md_vld", md_vld, 1'b0);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_err_cnt", {err, q_cnt}, '0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    rv = '{4'b0011, 32'h0000_0777, 0, 0, 1'b0, 1'b0, 0};
    run_pkt(rv);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ts_sched.md
Name: ts_sched

Overview:
- Transmission scheduler on the consuming end of the gate-control schedule interface.
- Samples the one-cycle schedule bitmap pulse from gate control and selects one queue by strict priority (Q0 highest).
- Pops that queue's metadata from the MB queue FIFO and hands the descriptor to EBM.
- Waits for EBM transmit completion before accepting the next schedule pulse; also supplies the Q2 read strobe that gate control uses for token consumption.

Parameters:
MD_WIDTH, 32, width of per-packet metadata word read from MB.
MD_TIMEOUT, 16, max cycles from FIFO read to metadata return before abort.
CNT_WIDTH, 16, width of per-queue dispatch counters.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
in_ts_schedule_valid  input  4  schedulable-queue bitmap from gate control; single-cycle pulse
out_ts_q_rden  output  4  one-hot metadata FIFO read strobe to MB queues
out_ts_q2_rden  output  1  copy of out_ts_q_rden[2] to gate control
in_ts_md_valid  input  1  metadata word valid from MB (returned after FIFO read)
in_ts_md  input  MD_WIDTH  metadata word from MB
out_ts_md_valid  output  1  descriptor valid to EBM
out_ts_md  output  MD_WIDTH  descriptor to EBM, copied from in_ts_md
out_ts_qid  output  2  queue id of current descriptor
in_ts_md_ready  input  1  EBM accepts descriptor
in_ts_pkt_done  input  1  EBM finished transmitting current packet (pulse)
out_ts_busy  output  1  high from selection until done/abort
out_ts_err  output  2  sticky: [0] schedule pulse while busy, [1] metadata timeout
out_ts_q_cnt  output  4*CNT_WIDTH  per-queue dispatched-packet counters; Qn in bits [n*CNT_WIDTH +: CNT_WIDTH]

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values:
  - out_ts_q_rden=0, out_ts_q2_rden=0, out_ts_md_valid=0, out_ts_md=0, out_ts_qid=0, out_ts_busy=0, out_ts_err=0, all counters=0.
  - state=IDLE_S.
- IDLE_S:
  - If in_ts_schedule_valid!=0, select the lowest set bit (Q0>Q1>Q2>Q3), latch qid, and go to READ_S.
  - Register the read strobes so out_ts_q_rden[qid] and out_ts_q2_rden (when qid=2) are high for exactly the next cycle. Latency from pulse to strobe is 1 cycle.
  - out_ts_busy goes high in the same cycle as the strobe.
- READ_S: strobe deasserts, timeout counter clears, go to WAIT_MD_S.
- WAIT_MD_S:
  - On in_ts_md_valid: capture in_ts_md into out_ts_md, assert out_ts_md_valid next cycle, go to SEND_S.
  - If MD_TIMEOUT cycles elapse without in_ts_md_valid: set out_ts_err[1], clear busy, return to IDLE_S. No counter increment.
- SEND_S:
  - Hold out_ts_md_valid, out_ts_md and out_ts_qid stable until in_ts_md_ready is high on a cycle where out_ts_md_valid is high.
  - On that accept cycle: out_ts_md_valid drops next cycle, counter[qid] increments by 1 (wraps at 2^CNT_WIDTH), go to WAIT_DONE_S.
- WAIT_DONE_S:
  - On in_ts_pkt_done: clear busy and return to IDLE_S.
  - A done pulse in any other state is ignored.
- IDLE_S is re-entered at least one cycle before a new selection is possible, so back-to-back packets cost a minimum of 5 cycles plus EBM time.
- Schedule pulse with any bit set while state != IDLE_S: ignored, out_ts_err[0] set.
- Bitmap with multiple bits set: only the highest-priority bit is served; the other bits are discarded, because gate control re-evaluates after the packet.
- in_ts_md_valid arriving in the same cycle as timeout expiry: the metadata wins, no error.
- in_ts_md_valid outside WAIT_MD_S: ignored.
- Errors are sticky until reset.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronous); any in-flight descriptor is dropped.

Test Plan:
- Pulse in_ts_schedule_valid=4'b0100 in IDLE_S -> next cycle out_ts_q_rden=4'b0100 and out_ts_q2_rden=1 for exactly 1 cycle. Return md=32'h0000_05DC 2 cycles later with ready=1 -> out_ts_md=32'h0000_05DC, out_ts_qid=2, cnt[2]=1.
- Pulse 4'b1110 -> only out_ts_q_rden=4'b0010 and out_ts_qid=1; out_ts_q2_rden stays 0.
- Hold in_ts_md_ready=0 for 10 cycles after descriptor -> out_ts_md_valid and out_ts_md stay stable for 10 cycles. Raise ready -> valid drops next cycle, counter increments once.
- Withhold in_ts_md_valid for 16 cycles after strobe -> out_ts_err[1]=1, busy=0, state IDLE_S, counters unchanged. A following pulse 4'b0001 is served normally.
- Pulse 4'b0001 while in WAIT_DONE_S -> no strobe, out_ts_err[0]=1. After in_ts_pkt_done, a new pulse 4'b0001 -> strobe 4'b0001.
- Preload cnt[3] to 16'hFFFF via 65535 dispatches on Q3 (or force), then dispatch once more -> cnt[3]=0. Assert rst_n=0 in SEND_S -> md_valid=0, busy=0 immediately.
